// File: rtl/sync_timing_pkg.sv
// Shared sync timing: default line/frame timing, sync polarities and the
// tracker lock-state encoding, used by the tracker and the sync generator.
package sync_timing_pkg;

  localparam int DefHorizontalBackPorch = 48;
  localparam int DefVisiblePixels       = 640;
  localparam int DefLineTotal           = 800;
  localparam int DefVerticalBackPorch   = 35;
  localparam int DefVisibleRows         = 400;
  localparam int DefFrameLines          = 449;

  localparam logic HsyncPolDefault = 1'b0;
  localparam logic VsyncPolDefault = 1'b1;

  localparam logic [9:0] CountMax = 10'd1023;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } trackState_t;

  function automatic logic inWindow(input logic [9:0] value,
                                    input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Registers one sync input and flags its end-of-pulse: the cycle where the
// registered copy is still active while the raw input has gone inactive.
module sync_edge
  import sync_timing_pkg::*;
#(
  parameter logic ActivePol = HsyncPolDefault
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sync,
  output logic o_eop
);

  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= ~ActivePol;
    else          r_sync <= i_sync;
  end

  assign o_eop = (r_sync == ActivePol) && (i_sync != ActivePol);

endmodule

// File: rtl/sync_tracker.sv
// Recovers pixel coordinates from HSYNC/VSYNC and verifies line/frame timing.
// Define SYNC_TRACKER_MEASURE_EN to add line/frame measurement and an error counter.
module sync_tracker
  import sync_timing_pkg::*;
#(
  parameter int   HorizontalBackPorch = DefHorizontalBackPorch,
  parameter int   VisiblePixels       = DefVisiblePixels,
  parameter int   LineTotal           = DefLineTotal,
  parameter int   VerticalBackPorch   = DefVerticalBackPorch,
  parameter int   VisibleRows         = DefVisibleRows,
  parameter int   FrameLines          = DefFrameLines,
  parameter logic HSYNC_POL           = HsyncPolDefault,
  parameter logic VSYNC_POL           = VsyncPolDefault
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_hsync,
  input  logic       i_vsync,
  output logic [9:0] o_x,
  output logic [8:0] o_y,
  output logic       o_visible,
  output logic       o_locked
`ifdef SYNC_TRACKER_MEASURE_EN
  ,
  output logic [10:0] o_measLine,
  output logic [9:0]  o_measFrame,
  output logic [7:0]  o_errCount
`endif
);

  localparam logic [9:0]  HStart  = 10'(HorizontalBackPorch);
  localparam logic [9:0]  HEnd    = 10'(HorizontalBackPorch + VisiblePixels - 1);
  localparam logic [9:0]  VStart  = 10'(VerticalBackPorch);
  localparam logic [9:0]  VEnd    = 10'(VerticalBackPorch + VisibleRows - 1);
  localparam logic [10:0] LineLen = 11'(LineTotal);
  localparam logic [9:0]  FrameLn = 10'(FrameLines);

  logic        w_hEop;
  logic        w_vEop;
  logic [10:0] w_lineLen;
  logic        w_hErr;
  logic        w_vErr;
  logic        w_err;
  logic        w_lostH;
  logic        w_vis;

  logic [9:0]  r_hcnt;
  logic [9:0]  r_lcnt;
  trackState_t r_state;
  logic        r_frameErr;
  logic        r_locked;
  logic        r_visible;
  logic [9:0]  r_x;
  logic [8:0]  r_y;

  sync_edge #(.ActivePol(HSYNC_POL)) u_hsyncEdge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sync  (i_hsync),
    .o_eop   (w_hEop)
  );

  sync_edge #(.ActivePol(VSYNC_POL)) u_vsyncEdge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sync  (i_vsync),
    .o_eop   (w_vEop)
  );

  assign w_lineLen = {1'b0, r_hcnt} + 11'd1;
  assign w_hErr    = w_hEop && (w_lineLen != LineLen);
  assign w_vErr    = w_vEop && (r_lcnt != FrameLn);
  assign w_err     = w_hErr || w_vErr;
  assign w_lostH   = (r_hcnt == CountMax);
  assign w_vis     = r_locked && inWindow(r_hcnt, HStart, HEnd) && inWindow(r_lcnt, VStart, VEnd);

  // A VSYNC end-of-pulse restarts the row count even if HSYNC ends in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hcnt <= '0;
      r_lcnt <= '0;
    end else begin
      if (w_hEop)        r_hcnt <= '0;
      else if (!w_lostH) r_hcnt <= r_hcnt + 10'd1;
      if (w_vEop)        r_lcnt <= '0;
      else if (w_hEop)   r_lcnt <= r_lcnt + 10'd1;
    end
  end

  // r_frameErr remembers any error since the last VSYNC, so a frame broken
  // while locked must be followed by one complete clean frame before relock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= SEARCH;
      r_locked   <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      if (w_vEop)     r_frameErr <= 1'b0;
      else if (w_err) r_frameErr <= 1'b1;

      if (w_lostH) begin
        r_state  <= SEARCH;
        r_locked <= 1'b0;
      end else begin
        case (r_state)
          SEARCH: begin
            if (w_vEop) r_state <= ACQUIRE;
          end
          ACQUIRE: begin
            if (w_vEop && !r_frameErr && !w_err) begin
              r_state  <= LOCKED;
              r_locked <= 1'b1;
            end
          end
          LOCKED: begin
            if (w_err) begin
              r_state  <= ACQUIRE;
              r_locked <= 1'b0;
            end
          end
          default: begin
            r_state  <= SEARCH;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_visible <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
    end else begin
      r_visible <= w_vis;
      r_x       <= w_vis ? (r_hcnt - HStart) : 10'd0;
      r_y       <= w_vis ? 9'(r_lcnt - VStart) : 9'd0;
    end
  end

  assign o_x       = r_x;
  assign o_y       = r_y;
  assign o_visible = r_visible;
  assign o_locked  = r_locked;

`ifdef SYNC_TRACKER_MEASURE_EN
  logic [10:0] r_measLine;
  logic [9:0]  r_measFrame;
  logic [7:0]  r_errCount;

  // Errors while still searching are not counted: there is no frame reference yet.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_measLine  <= '0;
      r_measFrame <= '0;
      r_errCount  <= '0;
    end else begin
      if (w_hEop) r_measLine  <= w_lineLen;
      if (w_vEop) r_measFrame <= r_lcnt;
      if (w_err && (r_state != SEARCH) && (r_errCount != 8'hFF))
        r_errCount <= r_errCount + 8'd1;
    end
  end

  assign o_measLine  = r_measLine;
  assign o_measFrame = r_measFrame;
  assign o_errCount  = r_errCount;
`else
  // Without measurement, timing errors only steer the lock state machine.
`endif

endmodule
